score_ctrl: RTL

Score controller that feeds the VGA score digit renderer. It arbitrates point events from two requesters (player 0 and player 1) with a level/pulse handshake and keeps per-player counts. It detects the winning score and publishes frame-stable score values, updated only at the vsync frame boundary, so the renderer never shows a digit change mid-frame.

---
 rtl/score_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/score_ctrl.sv
// score_ctrl: arbitrates point requests from two players, keeps per-player counts,
// detects the winning score and publishes frame-stable scores for the digit renderer.
//
// Optional feature macro: SCORE_FLASH_EN. When defined, the winner's digit blinks
// while the game is over, with a half-period of FLASH_FRAMES frames.
//
// Ports:
//   clk          system clock (vsync_i is synchronous to it)
//   rst_n        asynchronous active-low reset
//   pt0_req_i    player 0 point request, level, held until pt0_ack_o
//   pt1_req_i    player 1 point request, level, held until pt1_ack_o
//   vsync_i      VGA vsync, active-low; falling edge marks the frame boundary
//   restart_i    one-cycle pulse that starts a new game
//   pt0_ack_o    one-cycle grant pulse to player 0
//   pt1_ack_o    one-cycle grant pulse to player 1
//   score0_o     frame-latched player 0 count (right digit)
//   score1_o     frame-latched player 1 count (left digit)
//   digit_en_o   per-digit enable; bit0 = score0, bit1 = score1
//   game_over_o  high while the game is over
//   winner_o     2'b01 player 0 won, 2'b10 player 1 won, 2'b00 none
module score_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned FLASH_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pt0_req_i,
  input  logic       pt1_req_i,
  input  logic       vsync_i,
  input  logic       restart_i,
  output logic       pt0_ack_o,
  output logic       pt1_ack_o,
  output logic [3:0] score0_o,
  output logic [3:0] score1_o,
  output logic [1:0] digit_en_o,
  output logic       game_over_o,
  output logic [1:0] winner_o
);

  localparam logic [3:0] WinCnt = 4'(WIN_SCORE);

  typedef enum logic [1:0] {StPlay, StCheck, StOver} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [3:0] score0_q, score1_q;
  logic [1:0] winner_q, winner_d;
  logic       rr_q, rr_d;
  logic       ack0_q, ack0_d, ack1_q, ack1_d;
  logic       vsync_q;
  logic       frame_edge;

  assign frame_edge = vsync_q & ~vsync_i;

  always_comb begin
    state_d  = state_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    winner_d = winner_q;
    rr_d     = rr_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    if (restart_i) begin
      // Requests seen alongside restart stay pending for the next PLAY sample.
      cnt0_d   = 4'd0;
      cnt1_d   = 4'd0;
      winner_d = 2'b00;
      rr_d     = 1'b0;
      state_d  = StPlay;
    end else begin
      case (state_q)
        StPlay: begin
          if (pt0_req_i && pt1_req_i) begin
            rr_d = ~rr_q;
          end
          if (pt0_req_i && (!pt1_req_i || !rr_q)) begin
            ack0_d  = 1'b1;
            cnt0_d  = (cnt0_q < WinCnt) ? cnt0_q + 4'd1 : cnt0_q;
            state_d = StCheck;
          end else if (pt1_req_i) begin
            ack1_d  = 1'b1;
            cnt1_d  = (cnt1_q < WinCnt) ? cnt1_q + 4'd1 : cnt1_q;
            state_d = StCheck;
          end
        end
        StCheck: begin
          if (cnt0_q == WinCnt) begin
            winner_d = 2'b01;
            state_d  = StOver;
          end else if (cnt1_q == WinCnt) begin
            winner_d = 2'b10;
            state_d  = StOver;
          end else begin
            state_d = StPlay;
          end
        end
        StOver: begin
          // Ack and discard so no requester deadlocks; skip the cycle after an ack
          // while the requester is still dropping its level.
          ack0_d = pt0_req_i & ~ack0_q;
          ack1_d = pt1_req_i & ~ack1_q;
        end
        default: state_d = StPlay;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StPlay;
      cnt0_q   <= 4'd0;
      cnt1_q   <= 4'd0;
      score0_q <= 4'd0;
      score1_q <= 4'd0;
      winner_q <= 2'b00;
      rr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      vsync_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      winner_q <= winner_d;
      rr_q     <= rr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      vsync_q  <= vsync_i;
      // Latch the pre-update counts so a coincident increment shows next frame.
      if (frame_edge) begin
        score0_q <= cnt0_q;
        score1_q <= cnt1_q;
      end
    end
  end

`ifdef SCORE_FLASH_EN
  logic [7:0] flash_cnt_q, flash_cnt_d;
  logic       blink_q, blink_d;

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    blink_d     = blink_q;
    if (state_q != StOver || state_d != StOver) begin
      flash_cnt_d = 8'd0;
      blink_d     = 1'b0;
    end else if (frame_edge) begin
      if (flash_cnt_q >= 8'(FLASH_FRAMES - 1)) begin
        flash_cnt_d = 8'd0;
        blink_d     = ~blink_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // Only the winner's bit blinks; blink_q is zero outside OVER.
  assign digit_en_o = ~(winner_q & {2{blink_q}});
`else
  assign digit_en_o = 2'b11;
`endif

  assign pt0_ack_o   = ack0_q;
  assign pt1_ack_o   = ack1_q;
  assign score0_o    = score0_q;
  assign score1_o    = score1_q;
  assign winner_o    = winner_q;
  assign game_over_o = (state_q == StOver);

endmodule
